// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter block: FSM encoding,
// arbitration-mode encodings and default bus widths.
package mem_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_DATA_W = 32;

   localparam int unsigned PRIO_RR    = 0;
   localparam int unsigned PRIO_FIXED = 1;

   // Wide enough for the largest supported read latency (4)
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester + memory bus bundle for mem_arbiter; slave is the arbiter side,
// master is the requester/memory side.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]              rsp_rdata;
   logic                           mem_we;
   logic                           mem_re;
   logic [ADDR_W-1:0]              mem_addr;
   logic [DATA_W-1:0]              mem_wdata;
   logic [DATA_W-1:0]              mem_rdata;
   logic                           busy;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_we, mem_re,
             mem_addr, mem_wdata, busy
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_re,
             mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational request picker: round-robin from a pointer, or fixed
// priority (lowest index wins) when fixed_i is set.
module rr_picker #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               fixed_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // Walk channels starting at the base, wrapping NUM_REQ-1 -> 0
   always_comb begin
      int unsigned base;
      int unsigned j;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      base  = fixed_i ? 32'd0 : 32'(ptr_i);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = base + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel single-port memory arbiter: picks one requester, issues its
// access for one cycle and, for reads, returns data RD_LAT cycles later.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned PRIO_MODE = PRIO_RR
) (
   input  logic          clk,
   input  logic          nrst,
   mem_arbiter_if.slave  bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 fixed_mode;
   logic                 win_we;
   logic [ADDR_W-1:0]    win_addr;
   logic [DATA_W-1:0]    win_wdata;
   logic                 rsp_cycle;

   assign fixed_mode = (PRIO_MODE == PRIO_FIXED);

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .fixed_i (fixed_mode),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Winner's fields are only looked at while the access is being issued
   always_comb begin
      win_we    = bus.req_we[win_q];
      win_addr  = bus.req_addr[win_q];
      win_wdata = bus.req_wdata[win_q];
      rsp_cycle = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         win_oh_q <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         win_oh_q <= win_oh_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      win_oh_d = win_oh_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               win_d    = pick_idx;
               win_oh_d = pick_gnt;
               ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (win_we) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(RD_LAT);
            end
         end
         ST_WAIT: begin
            if (rsp_cycle) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               rdata_d = bus.mem_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state; read data passes through in the
   // response cycle and is held from rdata_q afterwards
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.rsp_rdata = rdata_q;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.busy      = (state_q != ST_IDLE);
      if (state_q == ST_ISSUE) begin
         bus.req_ready = win_oh_q;
         bus.mem_we    = win_we;
         bus.mem_re    = ~win_we;
         bus.mem_addr  = win_addr;
         bus.mem_wdata = win_wdata;
      end
      if (rsp_cycle) begin
         bus.rsp_valid = win_oh_q;
         bus.rsp_rdata = bus.mem_rdata;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of requester channels (2..8).
REQ-002 Parameter: ADDR_W, default 12, memory word-address width.
REQ-003 Parameter: DATA_W, default 32, data width.
REQ-004 Parameter: RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-005 Parameter: PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-006 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-007 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-008 Port: nrst, input, 1, asynchronous active-low reset.
REQ-009 Port: req_valid, input, NUM_REQ, per-channel access request.
REQ-010 Port: req_we, input, NUM_REQ, per-channel write (1) or read (0).
REQ-011 Port: req_addr, input, NUM_REQ x ADDR_W, per-channel address.
REQ-012 Port: req_wdata, input, NUM_REQ x DATA_W, per-channel write data.
REQ-013 Port: req_ready, output, NUM_REQ, one-hot accept pulse.
REQ-014 Port: rsp_valid, output, NUM_REQ, one-hot read-data-valid pulse.
REQ-015 Port: rsp_rdata, output, DATA_W, read data, shared by all channels.
REQ-016 Port: mem_we / mem_re, output, 1 each, memory write/read enable.
REQ-017 Port: mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W.
REQ-018 Port: busy, output, 1, high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-020 IDLE: if any req_valid is high, latch the winner index and go to ISSUE next cycle; otherwise stay.
REQ-021 Round-robin: search starts at rr_ptr and wraps from NUM_REQ-1 to 0; the first valid channel wins.
REQ-022 Fixed priority: the lowest-index valid channel wins; rr_ptr is ignored.
REQ-023 On grant, rr_ptr SHALL become winner+1 modulo NUM_REQ.
REQ-024 ISSUE (exactly one cycle): drive mem_addr/mem_wdata from the winner, set mem_we=req_we or mem_re=~req_we, and pulse req_ready[winner].
REQ-025 ISSUE, write: go to IDLE; a write occupies 2 cycles.
REQ-026 ISSUE, read: go to WAIT with a latency counter loaded to RD_LAT.
REQ-027 WAIT: decrement the counter each cycle; when it reaches 1, pulse rsp_valid[winner] with rsp_rdata=mem_rdata, then return to IDLE.
REQ-028 End-to-end read latency, from the ISSUE cycle to the rsp_valid cycle, SHALL be RD_LAT cycles.
REQ-029 Requesters hold req_valid and their fields stable until req_ready; the arbiter samples the fields only in ISSUE.
REQ-030 If the winner drops req_valid before ISSUE, the arbiter SHALL still issue the latched access (protocol violation, not detected).
REQ-031 Outside ISSUE, mem_we, mem_re and req_ready SHALL be 0.
REQ-032 Outside the response cycle, rsp_valid SHALL be 0.
REQ-033 rsp_rdata SHALL hold its last value between responses.
REQ-034 New requests arriving while busy SHALL wait; none are dropped or merged.

Reset
REQ-035 nrst low SHALL force immediately:
- state=IDLE, rr_ptr=0, counter=0
- all outputs 0, including rsp_rdata and mem_addr
REQ-036 Reset during ISSUE or WAIT SHALL abort the access; no rsp_valid is produced for it.

Structure
REQ-037 The shared package SHALL hold the FSM state enum, the PRIO_MODE encodings, and the default ADDR_W/DATA_W constants.
REQ-038 One sub-module, rr_picker, SHALL be combinational: req vector + pointer + mode -> one-hot grant + index.

Verification
REQ-039 Single write: ch1 writes addr 0x010, data 0xDEADBEEF -> ISSUE next cycle; mem_we=1; req_ready=3'b010; no rsp_valid.
REQ-040 Read, RD_LAT=2: ch0 reads 0x010 while mem model returns 0xDEADBEEF -> rsp_valid=3'b001 with that data, 2 cycles after ISSUE.
REQ-041 All three channels held valid, round-robin -> grants in order 0,1,2,0 with rr_ptr wrapping 2->0.
REQ-042 Same stimulus with PRIO_MODE=1 -> ch0 wins every arbitration; ch1 and ch2 starve while ch0 stays valid.
REQ-043 nrst asserted during WAIT of a ch2 read -> busy=0 and all outputs 0 immediately; no rsp_valid after release; next grant from rr_ptr=0.
REQ-044 NUM_REQ=8, write to addr 0xFFF with data all-ones -> mem_addr=0xFFF and mem_wdata=0xFFFFFFFF with no truncation.
